// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory stage: data memory, stack pointer, load/store, push/pop, CALL/RET frames
module mem_stage #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16,
  parameter logic [ADDR_W-1:0] SP_INIT = {ADDR_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic              push,
  input  logic              pop,
  input  logic              call,
  input  logic              ret,
  input  logic [DATA_W-1:0] aluResult,
  input  logic [DATA_W-1:0] storeData,
  input  logic [DATA_W-1:0] pcPlus1,
  input  logic [2:0]        flagsIn,
  output logic [DATA_W-1:0] readData,
  output logic [DATA_W-1:0] retPc,
  output logic [2:0]        retFlags,
  output logic              retValid,
  output logic              stall,
  output logic [ADDR_W-1:0] sp,
  output logic              stackErr
);

  typedef enum logic [1:0] {IDLE, CALL2, RET2} state_t;

  state_t              state, nextState;
  logic [DATA_W-1:0]   mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0]   addr;
  logic [ADDR_W-1:0]   spNext;
  logic [ADDR_W-1:0]   wrAddr;
  logic [DATA_W-1:0]   wrData;
  logic [ADDR_W-1:0]   rdAddr;
  logic [DATA_W-1:0]   readWord;
  logic                memWe;
  logic                rdLoad;
  logic                retFlagsLoad;
  logic                retPcLoad;
  logic                errSet;
  logic                unusedAddrBits;

  assign addr           = aluResult[ADDR_W-1:0];
  assign unusedAddrBits = ^aluResult[DATA_W-1:ADDR_W];
  assign readWord       = mem[rdAddr];

  // Strobe arbitration and frame sequencing; only the highest-priority strobe acts
  always_comb begin
    nextState    = state;
    stall        = 1'b0;
    spNext       = sp;
    memWe        = 1'b0;
    wrAddr       = sp;
    wrData       = storeData;
    rdAddr       = sp + 1'b1;
    rdLoad       = 1'b0;
    retFlagsLoad = 1'b0;
    retPcLoad    = 1'b0;
    errSet       = 1'b0;
    case (state)
      IDLE: begin
        if (call) begin
          memWe     = 1'b1;
          wrData    = pcPlus1;
          spNext    = sp - 1'b1;
          errSet    = (sp == '0);
          stall     = 1'b1;
          nextState = CALL2;
        end else if (ret) begin
          retFlagsLoad = 1'b1;
          spNext       = sp + 1'b1;
          errSet       = (sp == SP_INIT);
          stall        = 1'b1;
          nextState    = RET2;
        end else if (push) begin
          memWe  = 1'b1;
          spNext = sp - 1'b1;
          errSet = (sp == '0);
        end else if (pop) begin
          rdLoad = 1'b1;
          spNext = sp + 1'b1;
          errSet = (sp == SP_INIT);
        end else if (memWrite) begin
          memWe  = 1'b1;
          wrAddr = addr;
        end else if (memRead) begin
          rdLoad = 1'b1;
          rdAddr = addr;
        end
      end
      CALL2: begin
        memWe     = 1'b1;
        wrData    = {{(DATA_W-3){1'b0}}, flagsIn};
        spNext    = sp - 1'b1;
        errSet    = (sp == '0);
        nextState = IDLE;
      end
      RET2: begin
        retPcLoad = 1'b1;
        spNext    = sp + 1'b1;
        errSet    = (sp == SP_INIT);
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Data memory write port; contents survive reset, no writes while reset is held
  always_ff @(posedge clk) begin
    if (rst_n && memWe) begin
      mem[wrAddr] <= wrData;
    end
  end

  // Registered state, stack pointer, read results and sticky stack error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sp       <= SP_INIT;
      readData <= '0;
      retPc    <= '0;
      retFlags <= '0;
      retValid <= 1'b0;
      stackErr <= 1'b0;
    end else begin
      state    <= nextState;
      sp       <= spNext;
      retValid <= retPcLoad;
      if (rdLoad)       readData <= readWord;
      if (retFlagsLoad) retFlags <= readWord[2:0];
      if (retPcLoad)    retPc    <= readWord;
      if (errSet)       stackErr <= 1'b1;
    end
  end

endmodule
